// File: rtl/wt_mem_req_arbiter.sv
// Round-robin arbiter sharing one memory request port between cache requesters.
// Define WT_ARB_STALL_CNT_EN to build the store-limit stall counter.
module wt_mem_req_arbiter #(
    parameter int unsigned NR_PORTS       = 3,
    parameter int unsigned ADDR_WIDTH     = 64,
    parameter int unsigned DATA_WIDTH     = 64,
    parameter int unsigned TID_WIDTH      = 2,
    parameter int unsigned MAX_OUT_STORES = 7,
    parameter int unsigned MAX_OUT_LOADS  = 4,
    localparam int unsigned PB = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1,
    localparam int unsigned SW = $clog2(MAX_OUT_STORES + 1)
) (
    input  logic                             clk_i,
    input  logic                             rst_ni,
    input  logic [NR_PORTS-1:0]              req_valid_i,
    output logic [NR_PORTS-1:0]              req_ready_o,
    input  logic [NR_PORTS-1:0]              req_we_i,
    input  logic [NR_PORTS*ADDR_WIDTH-1:0]   req_addr_i,
    input  logic [NR_PORTS*DATA_WIDTH-1:0]   req_wdata_i,
    input  logic [NR_PORTS*TID_WIDTH-1:0]    req_tid_i,
    output logic                             mem_req_valid_o,
    input  logic                             mem_req_ready_i,
    output logic                             mem_req_we_o,
    output logic [ADDR_WIDTH-1:0]            mem_req_addr_o,
    output logic [DATA_WIDTH-1:0]            mem_req_wdata_o,
    output logic [TID_WIDTH+PB-1:0]          mem_req_tid_o,
    input  logic                             mem_rsp_valid_i,
    input  logic                             mem_rsp_we_i,
    input  logic [TID_WIDTH+PB-1:0]          mem_rsp_tid_i,
    input  logic [DATA_WIDTH-1:0]            mem_rsp_data_i,
    output logic [NR_PORTS-1:0]              rsp_valid_o,
    output logic [TID_WIDTH-1:0]             rsp_tid_o,
    output logic [DATA_WIDTH-1:0]            rsp_data_o,
    input  logic                             flush_i,
    output logic                             flush_ack_o,
    output logic [SW-1:0]                    out_stores_o,
    output logic [31:0]                      stall_cnt_o
);

    localparam int unsigned LW = $clog2(MAX_OUT_LOADS + 1);

    typedef enum logic {
        RUN,
        DRAIN
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic [PB-1:0]           ptr_q;
    logic [SW-1:0]           st_cnt_q;
    logic [LW-1:0]           ld_cnt_q;
    logic                    vld_q;
    logic                    we_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [TID_WIDTH+PB-1:0] tid_q;

    logic                    slot_free;
    logic                    st_ok;
    logic                    ld_ok;
    logic                    run;
    logic                    drained;
    logic                    found;
    logic                    grant;
    logic [NR_PORTS-1:0]     elig;
    logic [PB-1:0]           gidx;
    logic [PB-1:0]           cand;
    logic [PB-1:0]           rsp_idx;
    logic                    st_inc;
    logic                    st_dec;
    logic                    ld_inc;
    logic                    ld_dec;
    logic [ADDR_WIDTH-1:0]   sel_addr;
    logic [DATA_WIDTH-1:0]   sel_wdata;
    logic [TID_WIDTH-1:0]    sel_tid;

    assign slot_free = !vld_q || mem_req_ready_i;
    assign st_ok     = st_cnt_q < SW'(MAX_OUT_STORES);
    assign ld_ok     = ld_cnt_q < LW'(MAX_OUT_LOADS);
    assign drained   = !vld_q && (st_cnt_q == '0) && (ld_cnt_q == '0);

    always_comb begin
        elig = '0;
        for (int i = 0; i < int'(NR_PORTS); i++) begin
            elig[i] = req_valid_i[i] && (req_we_i[i] ? st_ok : ld_ok);
        end
    end

    // First eligible port after the last winner, wrapping around
    always_comb begin
        found = 1'b0;
        gidx  = ptr_q;
        cand  = '0;
        for (int k = 1; k <= int'(NR_PORTS); k++) begin
            cand = PB'((32'(ptr_q) + 32'(k)) % NR_PORTS);
            if (!found && elig[cand]) begin
                found = 1'b1;
                gidx  = cand;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        flush_ack_o = 1'b0;
        run         = 1'b0;
        unique case (state_q)
            RUN: begin
                if (flush_i) begin
                    state_d = DRAIN;
                end else begin
                    run = 1'b1;
                end
            end
            DRAIN: begin
                if (drained) begin
                    flush_ack_o = 1'b1;
                    state_d     = RUN;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    assign grant     = run && slot_free && found;
    assign sel_addr  = req_addr_i[32'(gidx)*ADDR_WIDTH +: ADDR_WIDTH];
    assign sel_wdata = req_wdata_i[32'(gidx)*DATA_WIDTH +: DATA_WIDTH];
    assign sel_tid   = req_tid_i[32'(gidx)*TID_WIDTH +: TID_WIDTH];

    always_comb begin
        req_ready_o = '0;
        for (int i = 0; i < int'(NR_PORTS); i++) begin
            req_ready_o[i] = grant && (gidx == PB'(i));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            tid_q   <= '0;
            ptr_q   <= PB'(NR_PORTS - 1);
        end else if (grant) begin
            vld_q   <= 1'b1;
            we_q    <= req_we_i[gidx];
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            tid_q   <= {gidx, sel_tid};
            ptr_q   <= gidx;
        end else if (slot_free) begin
            vld_q   <= 1'b0;
        end
    end

    assign mem_req_valid_o = vld_q;
    assign mem_req_we_o    = we_q;
    assign mem_req_addr_o  = addr_q;
    assign mem_req_wdata_o = wdata_q;
    assign mem_req_tid_o   = tid_q;

    // In-flight accounting runs from grant to response
    assign st_inc = grant && req_we_i[gidx];
    assign ld_inc = grant && !req_we_i[gidx];
    assign st_dec = mem_rsp_valid_i && mem_rsp_we_i;
    assign ld_dec = mem_rsp_valid_i && !mem_rsp_we_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_cnt_q <= '0;
            ld_cnt_q <= '0;
        end else begin
            if (st_inc && !st_dec) begin
                st_cnt_q <= st_cnt_q + 1'b1;
            end else if (st_dec && !st_inc && st_cnt_q != '0) begin
                st_cnt_q <= st_cnt_q - 1'b1;
            end
            if (ld_inc && !ld_dec) begin
                ld_cnt_q <= ld_cnt_q + 1'b1;
            end else if (ld_dec && !ld_inc && ld_cnt_q != '0) begin
                ld_cnt_q <= ld_cnt_q - 1'b1;
            end
        end
    end

    assign out_stores_o = st_cnt_q;

    assign rsp_idx = mem_rsp_tid_i[TID_WIDTH +: PB];

    always_comb begin
        rsp_valid_o = '0;
        for (int i = 0; i < int'(NR_PORTS); i++) begin
            rsp_valid_o[i] = mem_rsp_valid_i && (rsp_idx == PB'(i));
        end
    end

    assign rsp_tid_o  = mem_rsp_tid_i[TID_WIDTH-1:0];
    assign rsp_data_o = mem_rsp_data_i;

`ifdef WT_ARB_STALL_CNT_EN
    logic [31:0] stall_q;
    logic        st_blocked;

    assign st_blocked = (state_q == RUN) && slot_free
                        && (|(req_valid_i & req_we_i)) && !st_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stall_q <= '0;
        end else if (st_blocked) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_q;
`else
    assign stall_cnt_o = '0;
`endif

endmodule

// File: doc/wt_mem_req_arbiter.md
Name: wt_mem_req_arbiter

Overview:
- Shares the single memory request port of the write-through cache subsystem between NR_PORTS requesters: icache refill, dcache load miss, dcache write buffer.
- Round-robin grants into a registered request stage.
- Tags each request with the requester index and routes responses back by tag.
- Tracks outstanding loads/stores, enforces the store-outstanding limit, and provides a fence (drain-all) handshake.

Parameters:
- NR_PORTS, 3, number of requesters; port 2 is the write buffer by convention, but all ports are handled symmetrically.
- ADDR_WIDTH, 64, request address width.
- DATA_WIDTH, 64, write/read data width.
- TID_WIDTH, 2, requester-local transaction ID width.
- MAX_OUT_STORES, 7, maximum stores in flight, counted from grant to response.
- MAX_OUT_LOADS, 4, maximum loads in flight, counted from grant to response.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- req_valid_i  in  NR_PORTS  per-port request valid
- req_ready_o  out  NR_PORTS  per-port grant, one-hot or zero
- req_we_i  in  NR_PORTS  1 = store
- req_addr_i  in  NR_PORTS*ADDR_WIDTH  request addresses
- req_wdata_i  in  NR_PORTS*DATA_WIDTH  store data
- req_tid_i  in  NR_PORTS*TID_WIDTH  requester transaction IDs
- mem_req_valid_o  out  1  registered request valid
- mem_req_ready_i  in  1  memory accepts request
- mem_req_we_o  out  1  store flag
- mem_req_addr_o  out  ADDR_WIDTH  address
- mem_req_wdata_o  out  DATA_WIDTH  store data
- mem_req_tid_o  out  TID_WIDTH+PB  {port index, tid}; PB = max(1, clog2(NR_PORTS))
- mem_rsp_valid_i  in  1  response valid; no backpressure
- mem_rsp_we_i  in  1  response is a store ack
- mem_rsp_tid_i  in  TID_WIDTH+PB  echoed tag
- mem_rsp_data_i  in  DATA_WIDTH  load data
- rsp_valid_o  out  NR_PORTS  one-hot response strobe
- rsp_tid_o  out  TID_WIDTH  low bits of mem_rsp_tid_i
- rsp_data_o  out  DATA_WIDTH  mem_rsp_data_i passthrough
- flush_i  in  1  fence request, level
- flush_ack_o  out  1  one-cycle pulse when drained
- out_stores_o  out  clog2(MAX_OUT_STORES+1)  stores in flight
- stall_cnt_o  out  32  store-limit stall counter (optional feature)

Behaviour:
- Reset (async, rst_ni low): mem_req_valid_o=0, all mem_req_* payload=0, counters=0, RR pointer=NR_PORTS-1, state=RUN, flush_ack_o=0, stall_cnt_o=0. Reset mid-transaction discards all in-flight tracking.
- Slot free condition: !mem_req_valid_o || mem_req_ready_i.
- Eligible port: req_valid_i set, AND (store: out_stores < MAX_OUT_STORES) OR (load: out_loads < MAX_OUT_LOADS).
- Grant (state RUN, slot free, any eligible port):
  - Pick the first eligible port scanning from pointer+1 with wrap.
  - req_ready_o[g]=1 combinationally in the same cycle.
  - Next edge: payload registered, mem_req_valid_o=1, pointer=g.
  - Latency: grant to mem_req_valid_o is 1 cycle; full throughput of one request per cycle when mem_req_ready_i is held high.
- Stable output: while mem_req_valid_o && !mem_req_ready_i, all mem_req_* outputs are held stable and no grant is issued.
- Slot release: if the slot is consumed and no port is eligible, mem_req_valid_o drops to 0.
- Counters:
  - Increment at grant (store vs load counter by req_we_i).
  - Decrement on mem_rsp_valid_i, selected by mem_rsp_we_i.
  - Simultaneous increment and decrement on the same counter: net unchanged.
  - Decrement at zero saturates at 0.
- Response routing: rsp_valid_o[idx]=mem_rsp_valid_i, where idx is the upper PB bits of mem_rsp_tid_i; combinational, zero latency.
- Out-of-range index (idx >= NR_PORTS): no strobe on any port; the counter decrement still applies.
- FSM:
  - RUN: on flush_i=1, go to DRAIN. A grant in that same cycle is suppressed.
  - DRAIN: no grants. When mem_req_valid_o=0, out_loads=0 and out_stores=0, assert flush_ack_o for one cycle and return to RUN.
  - DRAIN always lasts at least one cycle, even if already drained on entry.
  - flush_i still high after return to RUN re-enters DRAIN; requesters deassert flush_i on ack.

Optional Feature:
- WT_ARB_STALL_CNT_EN defined: stall_cnt_o increments, wrapping at 2^32, each cycle in RUN where the slot is free, a store is requested, and it is blocked only by the MAX_OUT_STORES limit.
- Undefined: stall_cnt_o tied to 0 and no counter flops exist.

Test Plan:
- Round-robin: ports 0,1,2 load-valid continuously, mem_req_ready_i=1, MAX_OUT_LOADS large enough (or loads responded each cycle) -> grant order 0,1,2,0,1,2, one per cycle, mem_req_tid_o upper bits match.
- Store limit: port 2 issues 8 stores, no responses -> 7 granted, out_stores_o=7, 8th stalled; one store ack -> 8th granted the next cycle.
- Backpressure: mem_req_ready_i=0 for 5 cycles after a grant -> mem_req_* stable for 5 cycles, req_ready_o=0; ready=1 -> next request issued back-to-back.
- Simultaneous events: store granted in the same cycle as a store ack with out_stores_o=3 -> remains 3.
- Flush: 2 loads outstanding, flush_i=1 -> no grants; responses return -> flush_ack_o pulses once the cycle after the last response clears the counter.
- Bad tag: mem_rsp_tid_i index=3 with NR_PORTS=3 -> rsp_valid_o=0; with WT_ARB_STALL_CNT_EN, store-limit stalls of 4 cycles -> stall_cnt_o=4.
